// File: rtl/func_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// Optional feature macro: TT_CHECK_EN (expected-table comparison).
package func_sweep_pkg;

  localparam int MAX_INPUTS = 4;
  localparam int TT_WIDTH   = 16;
  localparam int ROW_W      = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  // Input count is usable only in the range 1..MAX_INPUTS.
  function automatic logic n_valid(input logic [2:0] n);
    return (n != 3'd0) && (n <= 3'(MAX_INPUTS));
  endfunction

  // Ones in every table position that a sweep over n inputs visits.
  function automatic logic [TT_WIDTH-1:0] row_mask(input logic [2:0] n);
    return ~({TT_WIDTH{1'b1}} << (5'd1 << n));
  endfunction

endpackage

// File: rtl/func_sweep_ctrl_if.sv
// Stimulus / capture bundle between the sweep controller and its user.
// Optional feature macro: TT_CHECK_EN adds exp and mismatch.
interface func_sweep_ctrl_if;
  import func_sweep_pkg::*;

  logic                start;
  logic                abort;
  logic [2:0]          n_in;
  logic [3:0]          din;
  logic                fout;
  logic                busy;
  logic                done;
  logic                err;
  logic [TT_WIDTH-1:0] tt;
`ifdef TT_CHECK_EN
  logic [TT_WIDTH-1:0] exp;
  logic                mismatch;

  modport master (output start, abort, n_in, fout, exp,
                  input  din, busy, done, err, tt, mismatch);
  modport slave  (input  start, abort, n_in, fout, exp,
                  output din, busy, done, err, tt, mismatch);
`else
  modport master (output start, abort, n_in, fout,
                  input  din, busy, done, err, tt);
  modport slave  (input  start, abort, n_in, fout,
                  output din, busy, done, err, tt);
`endif

endinterface

// File: rtl/sweep_row_counter.sv
// Row counter for the sweep: clear, increment, and last-row detect.
// Kept one bit wider than the row index so row 15 never aliases to 0.
module sweep_row_counter
  import func_sweep_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [2:0] n_lat,
  output logic [3:0] row,
  output logic       last
);

  logic [ROW_W-1:0] row_q, row_d;

  // Next row: clear dominates increment.
  always_comb begin
    row_d = row_q;
    if (clr) begin
      row_d = '0;
    end else if (inc) begin
      row_d = row_q + 5'd1;
    end
  end

  // Row register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign row  = row_q[3:0];
  assign last = (row_q == ((5'd1 << n_lat) - 5'd1));

endmodule

// File: rtl/func_sweep_ctrl.sv
// Truth-table sweep controller: walks every input row of a small
// combinational function, waits SETTLE cycles per row, captures fout.
// Optional feature macro: TT_CHECK_EN (compare capture against exp).
module func_sweep_ctrl
  import func_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input logic              clk,
  input logic              rst_n,
  func_sweep_ctrl_if.slave bus
);

  sweep_state_e        state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          n_q, n_d;
  logic [TT_WIDTH-1:0] tt_q, tt_d;
  logic                err_q, err_d;
  logic [3:0]          row;
  logic                last;
  logic                row_clr;
  logic                row_inc;
`ifdef TT_CHECK_EN
  logic [TT_WIDTH-1:0] exp_q, exp_d;
  logic                mis_q, mis_d;
`endif

  sweep_row_counter u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (row_clr),
    .inc   (row_inc),
    .n_lat (n_q),
    .row   (row),
    .last  (last)
  );

  // Next-state, capture and counter control; abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    tt_d    = tt_q;
    err_d   = err_q;
    row_clr = 1'b0;
    row_inc = 1'b0;
`ifdef TT_CHECK_EN
    exp_d   = exp_q;
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d     = bus.n_in;
          tt_d    = '0;
          cnt_d   = '0;
          row_clr = 1'b1;
`ifdef TT_CHECK_EN
          exp_d   = bus.exp;
          mis_d   = 1'b0;
`endif
          if (n_valid(bus.n_in)) begin
            err_d   = 1'b0;
            state_d = DRIVE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == 4'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        tt_d[row] = bus.fout;
        if (last) begin
          state_d = DONE;
`ifdef TT_CHECK_EN
          mis_d   = |((tt_d ^ exp_q) & row_mask(n_q));
`endif
        end else begin
          row_inc = 1'b1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      n_d     = n_q;
      tt_d    = tt_q;
      err_d   = err_q;
      row_clr = 1'b1;
      row_inc = 1'b0;
`ifdef TT_CHECK_EN
      exp_d   = exp_q;
      mis_d   = mis_q;
`endif
    end
  end

  // Controller state and captured results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      tt_q    <= '0;
      err_q   <= 1'b0;
`ifdef TT_CHECK_EN
      exp_q   <= '0;
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      tt_q    <= tt_d;
      err_q   <= err_d;
`ifdef TT_CHECK_EN
      exp_q   <= exp_d;
      mis_q   <= mis_d;
`endif
    end
  end

  assign bus.busy = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done = (state_q == DONE);
  assign bus.err  = err_q;
  assign bus.tt   = tt_q;
  assign bus.din  = bus.busy ? row : 4'd0;
`ifdef TT_CHECK_EN
  assign bus.mismatch = mis_q;
`endif

endmodule
